univ_shift_reg_seq: RTL
=======================

Name: univ_shift_reg_seq

Overview:
- Parametrised universal shift register, generalising the team's 4-bit S1/S0 register to WIDTH bits.
- Adds rotate, arithmetic-shift and clear modes.
- Adds a multi-bit shift sequencer: START/AMT launch a k-bit shift executed one bit per cycle, with BUSY/DONE handshake.
- Sits in the datapath as the shifter/accumulator register feeding the ALU and the serial I/O path.

Parameters:
- WIDTH, 16, register width in bits (minimum 2).
- AW, $clog2(WIDTH)+1, width of the AMT port; derived, not to be overridden.

Ports:
- CLOCK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- ENABLE  input  1  clock enable; low freezes all state including the sequencer
- MODE  input  3  operation select (encodings below)
- IN  input  WIDTH  parallel load data
- LIN  input  1  serial fill bit entering at the MSB on right shifts
- RIN  input  1  serial fill bit entering at the LSB on left shifts
- START  input  1  launch a sequenced operation of AMT steps
- AMT  input  AW  step count for START (0..WIDTH; larger values saturate to WIDTH)
- OUT  output  WIDTH  register contents
- SOUT_L  output  1  OUT[WIDTH-1], combinational from the register
- SOUT_R  output  1  OUT[0], combinational from the register
- BUSY  output  1  high while the sequencer is in SHIFT
- DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Sampled only at the CLOCK edge, and takes priority over ENABLE.
  - Sets OUT=0, state=IDLE, count=0, latched mode=HOLD, BUSY=0, DONE=0.
  - Reset during SHIFT aborts the operation; no DONE is produced.
- MODE encodings, one step:
  - 000 HOLD.
  - 001 SHR: {LIN, OUT[W-1:1]}.
  - 010 SHL: {OUT[W-2:0], RIN}.
  - 011 LOAD: IN.
  - 100 ROR: {OUT[0], OUT[W-1:1]}.
  - 101 ROL: {OUT[W-2:0], OUT[W-1]}.
  - 110 ASR: {OUT[W-1], OUT[W-1:1]}.
  - 111 CLR: 0.
- ENABLE=0: no state changes at all (OUT, state, count and DONE hold). DONE therefore stays high if ENABLE drops during a DONE cycle.
- State IDLE, START=0: apply one MODE step per enabled edge (free-running, backward-compatible behaviour). DONE=0.
- State IDLE, START=1 (enabled edge), with k = min(AMT, WIDTH):
  - k=0: OUT unchanged, next state DONE_ST.
  - k=1: apply one MODE step, next state DONE_ST.
  - k>=2: apply one MODE step on this edge, latch MODE, count<=k-1, next state SHIFT.
  - HOLD, LOAD and CLR with k>=1 execute once and go to DONE_ST regardless of k.
- State SHIFT:
  - Each enabled edge applies one step of the latched mode, sampling LIN/RIN live on that edge, and decrements count.
  - When count==1 on an edge, perform the final step and go to DONE_ST.
  - MODE, IN and START are ignored in this state.
- State DONE_ST: DONE=1 for exactly one cycle. On the next enabled edge the register behaves as in IDLE, so a new START is accepted there (back-to-back operation) and a free-running MODE step also applies.
- Latency: a k-step operation (k>=1) leaves its result in OUT after k enabled edges; DONE is high in the cycle following the k-th edge.
- BUSY = (state==SHIFT). BUSY is never asserted for k<=1.
- AMT values above WIDTH saturate to WIDTH. A full-width ROR or ROL therefore returns the original value.

Decomposition:
- Package univ_shift_pkg holds:
  - the MODE localparams (MODE_HOLD..MODE_CLR);
  - the sequencer state encodings (ST_IDLE, ST_SHIFT, ST_DONE, 2 bits).
- Sub-module shift_step_unit: purely combinational next-value function with inputs (mode, cur, IN, LIN, RIN) and output next. It is parametrised by WIDTH and instantiated once.
- The top level holds the register, the counter and the FSM.

Test Plan (WIDTH=8):
- Reset then free-run: RESET=1 for 1 cycle -> OUT=0x00, BUSY=0, DONE=0. Then LOAD IN=0xC3 -> OUT=0xC3; SHR with LIN=1 -> 0xE1; SHL with RIN=0 -> 0xC2.
- Sequenced rotate: OUT=0x81, START with MODE=ROR, AMT=3 -> OUT after edges: 0xC0, 0x60, 0x30. BUSY high for 2 cycles; DONE pulses in the cycle after the 3rd edge.
- ASR and saturation: OUT=0x90, START with ASR, AMT=2 -> 0xE4 and DONE. Then START with ROL, AMT=15 (saturates to 8) -> OUT returns to 0xE4 after 8 edges.
- Boundary counts: START with AMT=0 -> OUT unchanged, DONE next cycle, BUSY never high. START with LOAD, AMT=5 -> OUT=IN after 1 edge, DONE next cycle.
- ENABLE stall: during SHL with AMT=4, drop ENABLE for 3 cycles after the 2nd step -> OUT and count frozen. The operation completes 2 enabled edges after ENABLE returns; MODE/START changes while BUSY have no effect.
- Reset mid-operation: assert RESET during SHIFT -> next edge OUT=0x00, BUSY=0, no DONE. Then back-to-back STARTs issued in the DONE cycle are accepted.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_* : one-step operation encodings driven on MODE
//   seq_state_e : sequencer states (IDLE / SHIFT / DONE)
//   is_single_shot() : modes that run once no matter how many steps were asked for
package univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  // Repeating HOLD, LOAD or CLR gives the same result as doing it once.
  function automatic logic is_single_shot(input logic [2:0] m);
    return (m == MODE_HOLD) || (m == MODE_LOAD) || (m == MODE_CLR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational one-step next-value function of the shift register.
//   mode_i : operation select (MODE_* encodings)
//   cur_i  : current register value
//   in_i   : parallel load data
//   lin_i  : fill bit entering the MSB on SHR
//   rin_i  : fill bit entering the LSB on SHL
//   next_o : register value after one step
module shift_step_unit
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             lin_i,
  input  logic             rin_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    case (mode_i)
      MODE_HOLD: next_o = cur_i;
      MODE_SHR:  next_o = {lin_i, cur_i[WIDTH-1:1]};
      MODE_SHL:  next_o = {cur_i[WIDTH-2:0], rin_i};
      MODE_LOAD: next_o = in_i;
      MODE_ROR:  next_o = {cur_i[0], cur_i[WIDTH-1:1]};
      MODE_ROL:  next_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      MODE_ASR:  next_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      MODE_CLR:  next_o = '0;
      default:   next_o = cur_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal WIDTH-bit shift register with a multi-step sequencer.
// Free-runs one MODE step per enabled edge while idle; START launches a
// k-step operation (k = min(AMT, WIDTH)) executed one step per edge.
//   CLOCK, RESET   : clock, synchronous active-high reset (beats ENABLE)
//   ENABLE         : clock enable, freezes all state when low
//   MODE, IN       : operation select, parallel load data
//   LIN, RIN       : serial fill bits for SHR / SHL
//   START, AMT     : launch a sequenced operation of AMT steps
//   OUT            : register contents
//   SOUT_L, SOUT_R : MSB / LSB of OUT
//   BUSY, DONE     : sequencer in SHIFT / one-cycle completion pulse
module univ_shift_reg_seq
  import univ_shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] IN,
  input  logic             LIN,
  input  logic             RIN,
  input  logic             START,
  input  logic [AW-1:0]    AMT,
  output logic [WIDTH-1:0] OUT,
  output logic             SOUT_L,
  output logic             SOUT_R,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [AW-1:0] W_AMT = AW'(WIDTH);

  seq_state_e       state_q;
  logic [AW-1:0]    cnt_q;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       step_mode;
  logic [AW-1:0]    k_sat;

  // Once an operation is in SHIFT the latched mode drives the step unit.
  assign step_mode = (state_q == ST_SHIFT) ? mode_q : MODE;
  assign k_sat     = (AMT > W_AMT) ? W_AMT : AMT;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode_i (step_mode),
    .cur_i  (out_q),
    .in_i   (IN),
    .lin_i  (LIN),
    .rin_i  (RIN),
    .next_o (out_d)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      out_q   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else if (ENABLE) begin
      case (state_q)
        ST_SHIFT: begin
          out_q <= out_d;
          cnt_q <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_q <= ST_DONE;
        end
        default: begin
          // IDLE and DONE both accept new work, enabling back-to-back STARTs.
          if (START) begin
            if (k_sat == '0) begin
              state_q <= ST_DONE;
            end else begin
              out_q <= out_d;
              if (k_sat == AW'(1) || is_single_shot(MODE)) begin
                state_q <= ST_DONE;
              end else begin
                mode_q  <= MODE;
                cnt_q   <= k_sat - AW'(1);
                state_q <= ST_SHIFT;
              end
            end
          end else begin
            out_q   <= out_d;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign OUT    = out_q;
  assign SOUT_L = out_q[WIDTH-1];
  assign SOUT_R = out_q[0];
  assign BUSY   = (state_q == ST_SHIFT);
  assign DONE   = (state_q == ST_DONE);

endmodule
